// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arb_pkg                                                         |
// | Shared types and reset constants for the data-memory arbiter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRET = 2'd1,
        S_DRET = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    // The core wins the first conflict after reset.
    localparam owner_t RST_LAST_GNT = OWN_DMA;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2                                                              |
// | Two-way round-robin picker; req[0]=core, req[1]=DMA, one-hot gnt.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    owner_t r_last_gnt;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (r_last_gnt == OWN_DMA) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= RST_LAST_GNT;
        end else if (advance) begin
            r_last_gnt <= gnt[1] ? OWN_DMA : OWN_CORE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Shares one synchronous-read data-memory port between core and DMA.   |
// | Optional: DMEM_ARB_PERF_EN adds a saturating conflict_cnt output.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   conflict_cnt
`endif
);

    arb_state_t r_state;
    logic       w_ce;
    logic       w_de;
    logic [1:0] w_req;
    logic [1:0] w_gnt;

    // In S_CRET the held core request is the one completing, so mask it.
    assign w_ce  = c_req && (r_state != S_CRET);
    assign w_de  = d_req;
    assign w_req = {w_de, w_ce} & {2{~reset}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .advance (|w_gnt),
        .gnt     (w_gnt)
    );

    assign c_gnt = w_gnt[0];
    assign d_gnt = w_gnt[1];
    assign m_en  = |w_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign c_rvalid = (r_state == S_CRET) && !reset;
    assign d_rvalid = (r_state == S_DRET) && !reset;
    assign c_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign c_stall  = c_req && (r_state != S_CRET) && !(c_gnt && c_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (c_gnt && !c_we) begin
            r_state <= S_CRET;
        end else if (d_gnt && !d_we) begin
            r_state <= S_DRET;
        end else begin
            r_state <= S_IDLE;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_ce && w_de && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the core load/store path (MemWrite/ALUResult/WriteData/ReadData side of riscv_single) and a DMA/debug requester.
- Targets a synchronous-read data memory (1-cycle read latency).
- Produces a core stall so the core holds loads and stores until they complete.
- Sits between the core, the DMA master and the data memory in the top level.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- c_req  in  1  core memory access request (held while c_stall)
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_gnt  out  1  core access issued to memory this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DW  core read data
- c_stall  out  1  core must hold PC and request
- d_req  in  1  DMA request (payload stable until d_gnt)
- d_we  in  1  DMA write/read
- d_addr  in  AW  DMA address
- d_wdata  in  DW  DMA write data
- d_gnt  out  1  DMA access issued this cycle
- d_rvalid  out  1  DMA read data valid
- d_rdata  out  DW  DMA read data
- m_en  out  1  memory enable
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid the cycle after m_en && !m_we

Behaviour:
- One clock domain (clk). reset is synchronous and active-high.
- State register: S_IDLE, S_CRET (core read data returning), S_DRET (DMA read data returning).
- Round-robin pointer last_gnt in {CORE, DMA}.
- Reset values: state=S_IDLE, last_gnt=DMA, so the core wins the first conflict.
- While reset is high: c_gnt=d_gnt=m_en=m_we=0, c_rvalid=d_rvalid=0, m_addr=m_wdata=0.
- Eligibility:
  - ce = c_req && state!=S_CRET. In S_CRET the held core request is the one completing, so it is masked.
  - de = d_req.
- Grant (combinational, same cycle):
  - Only ce: core wins.
  - Only de: DMA wins.
  - Both: the requester that is not last_gnt wins.
  - On any grant, last_gnt <= winner.
- Memory drive:
  - m_en=1 iff a grant occurs.
  - m_we, m_addr, m_wdata come from the winner.
  - With no grant, m_we=0 and m_addr=m_wdata=0.
- Writes complete in the grant cycle.
- Next state:
  - S_CRET if the core wins a read.
  - S_DRET if the DMA wins a read.
  - Otherwise S_IDLE.
- Read return:
  - c_rvalid = (state==S_CRET); d_rvalid = (state==S_DRET).
  - c_rdata = d_rdata = m_rdata (consumers qualify with rvalid).
- A new grant in a return cycle is allowed (back-to-back, full throughput): the DMA may be granted in S_CRET, and the core in S_DRET.
- c_stall = c_req && state!=S_CRET && !(c_gnt && c_we).
  - Core write: 0 cycles of stall when granted.
  - Core read: stall in the grant cycle, released in the return cycle.
  - Stalls persist while losing arbitration.
- A DMA request not granted is held; d_req may change freely after d_gnt.
- Reset mid-read: the in-flight read is dropped; no rvalid is issued after the reset edge.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds output port conflict_cnt (32 bits).
  - Increments on every cycle with ce && de.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: no port, no counter logic.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum {S_IDLE, S_CRET, S_DRET}.
  - owner_t enum {OWN_CORE, OWN_DMA}.
  - Reset constant RST_LAST_GNT=OWN_DMA.
- Sub-module rr_arb2:
  - 2-way round-robin picker holding the last_gnt register.
  - Inputs: req[1:0], advance. Outputs: one-hot gnt.

Test Plan:
- Core write alone, c_addr=0x10, c_wdata=0xDEADBEEF -> same cycle c_gnt=1, m_en=1, m_we=1, m_addr=0x10, c_stall=0.
- Core read 0x10 after the above -> cycle0 c_stall=1, m_en=1, m_we=0; cycle1 c_rvalid=1, c_rdata=0xDEADBEEF, c_stall=0, m_en=0.
- Right after reset, both request writes continuously -> cycle0 c_gnt=1, d_gnt=0; cycle1 d_gnt=1; cycle2 c_gnt=1 (alternation).
- Core read granted cycle0, DMA read 0x20 pending -> cycle1 c_rvalid=1 and d_gnt=1 together; cycle2 d_rvalid=1, d_rdata=mem[0x20].
- Core read granted, reset high in the next cycle -> no c_rvalid after the edge, state=S_IDLE; next conflict goes to the core.
- With DMEM_ARB_PERF_EN, 3 conflict cycles then idle -> conflict_cnt=3, held steady.
